// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared CPU definitions for hazard and forwarding control:
// register-index width and execute operand-source encodings.
package hazard_fwd_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// Per-operand producer match: near producer (a) wins over far producer (b),
// and writes to index 0 never match.
module fwd_match
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_rs,
    input  logic          i_use,
    input  logic [AW-1:0] i_a_rd,
    input  logic          i_a_wr,
    input  logic [AW-1:0] i_b_rd,
    input  logic          i_b_wr,
    output fwd_sel_e      o_sel
);

    logic w_a_hit;
    logic w_b_hit;

    assign w_a_hit = i_use & i_a_wr & (i_a_rd != '0) & (i_a_rd == i_rs);
    assign w_b_hit = i_use & i_b_wr & (i_b_rd != '0) & (i_b_rd == i_rs);

    always_comb begin
        o_sel = FWD_REG;
        if (w_a_hit) begin
            o_sel = FWD_MEM;
        end else if (w_b_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall, branch flush and operand forwarding control for a
// five-stage pipeline, driven by per-stage shadows of register usage.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = hazard_fwd_ctrl_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] D_rs1,
    input  logic [REG_AW-1:0] D_rs2,
    input  logic [REG_AW-1:0] D_rd,
    input  logic              D_use_rs1,
    input  logic              D_use_rs2,
    input  logic              D_reg_write,
    input  logic              D_is_load,
    input  logic              E_branch_taken,
    output logic              D_rs1_data_sel,
    output logic              D_rs2_data_sel,
    output logic [1:0]        E_rs1_data_sel,
    output logic [1:0]        E_rs2_data_sel,
    output logic              stall,
    output logic              flush
);

    logic [REG_AW-1:0] r_e_rs1;
    logic [REG_AW-1:0] r_e_rs2;
    logic [REG_AW-1:0] r_e_rd;
    logic              r_e_use1;
    logic              r_e_use2;
    logic              r_e_rw;
    logic              r_e_ld;
    logic [REG_AW-1:0] r_m_rd;
    logic              r_m_rw;
    logic              r_m_ld;
    logic [REG_AW-1:0] r_w_rd;
    logic              r_w_rw;

    logic              w_load_use;
    logic              w_bubble;
    logic              w_m_fwd_ok;
    fwd_sel_e          w_d1_sel;
    fwd_sel_e          w_d2_sel;
    fwd_sel_e          w_e1_sel;
    fwd_sel_e          w_e2_sel;

    assign w_load_use = r_e_ld & r_e_rw & (r_e_rd != '0)
                      & ((D_use_rs1 & (D_rs1 == r_e_rd))
                       | (D_use_rs2 & (D_rs2 == r_e_rd)));

    assign w_bubble = w_load_use | E_branch_taken;

    // Load data is not ready in M, so only ALU results forward from there.
    assign w_m_fwd_ok = r_m_rw & ~r_m_ld;

    fwd_match #(.AW(REG_AW)) u_d1 (
        .i_rs   (D_rs1),
        .i_use  (D_use_rs1),
        .i_a_rd ('0),
        .i_a_wr (1'b0),
        .i_b_rd (r_w_rd),
        .i_b_wr (r_w_rw),
        .o_sel  (w_d1_sel)
    );

    fwd_match #(.AW(REG_AW)) u_d2 (
        .i_rs   (D_rs2),
        .i_use  (D_use_rs2),
        .i_a_rd ('0),
        .i_a_wr (1'b0),
        .i_b_rd (r_w_rd),
        .i_b_wr (r_w_rw),
        .o_sel  (w_d2_sel)
    );

    fwd_match #(.AW(REG_AW)) u_e1 (
        .i_rs   (r_e_rs1),
        .i_use  (r_e_use1),
        .i_a_rd (r_m_rd),
        .i_a_wr (w_m_fwd_ok),
        .i_b_rd (r_w_rd),
        .i_b_wr (r_w_rw),
        .o_sel  (w_e1_sel)
    );

    fwd_match #(.AW(REG_AW)) u_e2 (
        .i_rs   (r_e_rs2),
        .i_use  (r_e_use2),
        .i_a_rd (r_m_rd),
        .i_a_wr (w_m_fwd_ok),
        .i_b_rd (r_w_rd),
        .i_b_wr (r_w_rw),
        .o_sel  (w_e2_sel)
    );

    assign D_rs1_data_sel = ~rst & (w_d1_sel == FWD_WB);
    assign D_rs2_data_sel = ~rst & (w_d2_sel == FWD_WB);
    assign E_rs1_data_sel = rst ? FWD_REG : w_e1_sel;
    assign E_rs2_data_sel = rst ? FWD_REG : w_e2_sel;
    assign stall          = ~rst & w_load_use & ~E_branch_taken;
    assign flush          = ~rst & E_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_rs1  <= '0;
            r_e_rs2  <= '0;
            r_e_rd   <= '0;
            r_e_use1 <= 1'b0;
            r_e_use2 <= 1'b0;
            r_e_rw   <= 1'b0;
            r_e_ld   <= 1'b0;
            r_m_rd   <= '0;
            r_m_rw   <= 1'b0;
            r_m_ld   <= 1'b0;
            r_w_rd   <= '0;
            r_w_rw   <= 1'b0;
        end else begin
            if (w_bubble) begin
                r_e_rs1  <= '0;
                r_e_rs2  <= '0;
                r_e_rd   <= '0;
                r_e_use1 <= 1'b0;
                r_e_use2 <= 1'b0;
                r_e_rw   <= 1'b0;
                r_e_ld   <= 1'b0;
            end else begin
                r_e_rs1  <= D_rs1;
                r_e_rs2  <= D_rs2;
                r_e_rd   <= D_rd;
                r_e_use1 <= D_use_rs1;
                r_e_use2 <= D_use_rs2;
                r_e_rw   <= D_reg_write;
                r_e_ld   <= D_is_load;
            end
            r_m_rd <= r_e_rd;
            r_m_rw <= r_e_rw;
            r_m_ld <= r_e_ld;
            r_w_rd <= r_m_rd;
            r_w_rw <= r_m_rw;
        end
    end

endmodule
